// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and slave FSM state encoding
package spi_pkg;

   // Default frame width for the 16-bit slave
   localparam int SPI_DATA_W = 16;

   // SPI mode 3: CPOL=1 (SCLK idles high), CPHA=1 (sample on trailing/rising edge)
   localparam logic [1:0] SPI_MODE = 2'd3;
   localparam logic       SPI_CPOL = SPI_MODE[1];

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_WAIT_SS = 2'd2
   } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rise/fall detect
module spi_sync_edge #(
   parameter int   SYNC_STG = 2,
   parameter logic RST_VAL  = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   // s[SYNC_STG-1] is the synchronised level, s[SYNC_STG] its previous value
   logic [SYNC_STG:0] s;

   // Shift the asynchronous input through the synchroniser chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s <= {(SYNC_STG+1){RST_VAL}};
      else        s <= {s[SYNC_STG-1:0], din};
   end

   assign rise = s[SYNC_STG-1] & ~s[SYNC_STG];
   assign fall = ~s[SYNC_STG-1] & s[SYNC_STG];

endmodule

// File: rtl/spi_slv16.sv
// rtl/spi_slv16.sv - 16-bit mode-3 SPI slave; SPI_SLV_FRAME_ERR_EN adds frm_err
module spi_slv16
   import spi_pkg::*;
#(
   parameter int DATA_W   = SPI_DATA_W,
   parameter int SYNC_STG = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SCLK,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   input  logic              wrt,
   input  logic [DATA_W-1:0] tx_data,
   output logic              rdy,
   output logic [DATA_W-1:0] rx_data
`ifdef SPI_SLV_FRAME_ERR_EN
   ,
   output logic              frm_err
`endif
);

   localparam int              CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

   spi_state_t        state, nxt;
   logic              sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic [SYNC_STG-1:0] mosi_q;
   logic              mosi_s;
   logic              done;
   logic              armed;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] rx_shift, tx_shift, tx_buf;

   spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(SPI_CPOL)) u_sclk_sync (
      .clk(clk), .rst_n(rst_n), .din(SCLK), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_ss_sync (
      .clk(clk), .rst_n(rst_n), .din(SS_n), .rise(ss_rise), .fall(ss_fall)
   );

   // MOSI goes through the same depth so its bit lines up with the SCLK edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mosi_q <= '0;
      else        mosi_q <= {mosi_q[SYNC_STG-2:0], MOSI};
   end
   assign mosi_s = mosi_q[SYNC_STG-1];

   assign MISO = tx_shift[DATA_W-1];

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nxt;
   end

   // Next state; a full frame wins over a simultaneous SS_n release
   always_comb begin
      nxt  = state;
      done = 1'b0;
      case (state)
         ST_IDLE:    if (ss_fall) nxt = ST_ACTIVE;
         ST_ACTIVE: begin
            if (bit_cnt == FULL) begin
               nxt  = ST_WAIT_SS;
               done = 1'b1;
            end else if (ss_rise) begin
               nxt = ST_IDLE;
            end
         end
         ST_WAIT_SS: if (ss_rise) nxt = ST_IDLE;
         default:    nxt = ST_IDLE;
      endcase
   end

   // Shift registers, bit counter, response buffer and completion outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy      <= 1'b0;
         rx_data  <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
         tx_buf   <= '0;
         bit_cnt  <= '0;
         armed    <= 1'b0;
      end else begin
         rdy <= done;
         if (wrt)  tx_buf  <= tx_data;
         if (done) rx_data <= rx_shift;
         case (state)
            ST_IDLE: begin
               if (ss_fall) begin
                  tx_shift <= wrt ? tx_data : tx_buf;
                  bit_cnt  <= '0;
                  armed    <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (!done) begin
                  if (sclk_rise) begin
                     rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                     bit_cnt  <= bit_cnt + 1'b1;
                     armed    <= 1'b1;
                  end
                  // The frame-opening fall arrives unarmed so the MSB stays on MISO
                  if (sclk_fall && armed) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SPI_SLV_FRAME_ERR_EN
   // Sticky error: short frame or SCLK overrun; a new set beats a clearing wrt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm_err <= 1'b0;
      end else if ((state == ST_ACTIVE && bit_cnt != FULL && ss_rise) ||
                   (state == ST_WAIT_SS && sclk_rise)) begin
         frm_err <= 1'b1;
      end else if (wrt) begin
         frm_err <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_spi_slv16.sv
// tb/tb_spi_slv16.sv - directed mode-3 master bench for spi_slv16
module tb_spi_slv16;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        SCLK    = 1'b1;
   logic        SS_n    = 1'b1;
   logic        MOSI    = 1'b0;
   logic        wrt     = 1'b0;
   logic [15:0] tx_data = 16'h0;
   logic        MISO;
   logic        rdy;
   logic [15:0] rx_data;
`ifdef SPI_SLV_FRAME_ERR_EN
   logic        frm_err;
`endif

   int          checks  = 0;
   int          errors  = 0;
   int          rdy_cnt = 0;
   int          r0;
   logic [15:0] mw;
   logic        m;

   spi_slv16 dut (
      .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
      .wrt(wrt), .tx_data(tx_data), .rdy(rdy), .rx_data(rx_data)
`ifdef SPI_SLV_FRAME_ERR_EN
      , .frm_err(frm_err)
`endif
   );

   // 10-unit system clock
   always #5 clk = ~clk;

   // Count every clk cycle in which rdy is high
   always @(negedge clk) if (rdy === 1'b1) rdy_cnt++;

   // Global time bound
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running required done");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_wrt(input logic [15:0] w);
      tx_data = w;
      wrt     = 1'b1;
      tick(1);
      wrt     = 1'b0;
   endtask

   // Select with 8-clk porch; optionally strobe wrt in the synchronised-fall cycle
   task automatic ss_start(input bit fall_wrt, input logic [15:0] w);
      SS_n = 1'b0;
      if (fall_wrt) begin
         tick(2);
         pulse_wrt(w);
         tick(5);
      end else begin
         tick(8);
      end
   endtask

   task automatic ss_end();
      tick(8);
      SS_n = 1'b1;
      tick(8);
   endtask

   // One 32-clk SCLK period: fall, drive MOSI, sample MISO just before the rise
   task automatic clk_bit(input logic b, output logic mo);
      SCLK = 1'b0;
      MOSI = b;
      tick(16);
      mo   = MISO;
      SCLK = 1'b1;
      tick(16);
   endtask

   task automatic frame(input logic [15:0] mosi_w, input int nbits, input bit mid_wrt,
                        input logic [15:0] mid_word, output logic [15:0] miso_w);
      logic mo;
      logic b;
      miso_w = 16'h0;
      for (int i = 0; i < nbits; i++) begin
         if (mid_wrt && i == 8) pulse_wrt(mid_word);
         b = (i < 16) ? mosi_w[15 - (i % 16)] : 1'b1;
         clk_bit(b, mo);
         if (i < 16) miso_w[15 - i] = mo;
      end
   endtask

   initial begin
      tick(3);
      check("reset_miso", {31'd0, MISO}, 32'h0);
      check("reset_rdy", {31'd0, rdy}, 32'h0);
      check("reset_rx_data", {16'd0, rx_data}, 32'h0);
      rst_n = 1'b1;
      tick(4);

      // 1: basic frame
      pulse_wrt(16'hA5C3);
      r0 = rdy_cnt;
      ss_start(1'b0, 16'h0);
      frame(16'h1234, 16, 1'b0, 16'h0, mw);
      ss_end();
      check("t1_miso", {16'd0, mw}, 32'hA5C3);
      check("t1_rx_data", {16'd0, rx_data}, 32'h1234);
      check("t1_rdy_pulses", rdy_cnt - r0, 1);

      // 2: back-to-back frames with reload between
      pulse_wrt(16'h0F0F);
      r0 = rdy_cnt;
      ss_start(1'b0, 16'h0);
      frame(16'hFFFF, 16, 1'b0, 16'h0, mw);
      ss_end();
      check("t2a_miso", {16'd0, mw}, 32'h0F0F);
      check("t2a_rx_data", {16'd0, rx_data}, 32'hFFFF);
      pulse_wrt(16'hF0F0);
      ss_start(1'b0, 16'h0);
      frame(16'h0000, 16, 1'b0, 16'h0, mw);
      ss_end();
      check("t2b_miso", {16'd0, mw}, 32'hF0F0);
      check("t2b_rx_data", {16'd0, rx_data}, 32'h0000);
      check("t2_rdy_pulses", rdy_cnt - r0, 2);

      // 3: abort after 9 bits
      pulse_wrt(16'h1111);
      r0 = rdy_cnt;
      ss_start(1'b0, 16'h0);
      frame(16'hABCD, 9, 1'b0, 16'h0, mw);
      ss_end();
      check("t3_rx_data_held", {16'd0, rx_data}, 32'h0000);
      check("t3_no_rdy", rdy_cnt - r0, 0);
`ifdef SPI_SLV_FRAME_ERR_EN
      check("t3_frm_err", {31'd0, frm_err}, 32'h1);
`endif

      // 4: wrt in the SS_n-fall cycle bypasses tx_buf; mid-frame wrt waits a frame
      pulse_wrt(16'h1111);
      ss_start(1'b1, 16'h5555);
      frame(16'h2468, 16, 1'b1, 16'h3C3C, mw);
      ss_end();
      check("t4a_miso_bypass", {16'd0, mw}, 32'h5555);
      check("t4a_rx_data", {16'd0, rx_data}, 32'h2468);
      ss_start(1'b0, 16'h0);
      frame(16'h1357, 16, 1'b0, 16'h0, mw);
      ss_end();
      check("t4b_miso_next", {16'd0, mw}, 32'h3C3C);
      check("t4b_rx_data", {16'd0, rx_data}, 32'h1357);

      // 5: reset at bit 7
      pulse_wrt(16'hFFFF);
      r0 = rdy_cnt;
      ss_start(1'b0, 16'h0);
      for (int i = 0; i < 7; i++) clk_bit(1'b1, m);
      rst_n = 1'b0;
      #1;
      check("t5_miso_rst", {31'd0, MISO}, 32'h0);
      check("t5_rdy_rst", {31'd0, rdy}, 32'h0);
      check("t5_rx_data_rst", {16'd0, rx_data}, 32'h0);
      SCLK = 1'b1;
      SS_n = 1'b1;
      MOSI = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(4);
      pulse_wrt(16'hC3A5);
      ss_start(1'b0, 16'h0);
      frame(16'h6B2D, 16, 1'b0, 16'h0, mw);
      ss_end();
      check("t5_miso_after", {16'd0, mw}, 32'hC3A5);
      check("t5_rx_data_after", {16'd0, rx_data}, 32'h6B2D);
      check("t5_rdy_pulses", rdy_cnt - r0, 1);

      // 6: 17th SCLK rise before SS_n release
      pulse_wrt(16'h0F0F);
      r0 = rdy_cnt;
      ss_start(1'b0, 16'h0);
      frame(16'h9E37, 17, 1'b0, 16'h0, mw);
      ss_end();
      check("t6_rx_data", {16'd0, rx_data}, 32'h9E37);
      check("t6_rdy_pulses", rdy_cnt - r0, 1);
`ifdef SPI_SLV_FRAME_ERR_EN
      check("t6_frm_err", {31'd0, frm_err}, 32'h1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
